rx_frame_sr: RTL and testbench

Parametrised receive shift register with frame assembly and buffering for the serial receive path. It sits behind the edge detector and collects one data bit per qualified SCL rising edge. After every DATA_WIDTH bits it pushes the assembled word into an internal first-word-fall-through FIFO, so a controller can read whole words rather than sample a single 128-bit parallel register.

---
 rtl/rx_frame_sr.sv | 136 +++++++++++++
 tb/tb_rx_frame_sr.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_sr.sv
// rx_frame_sr
// Receive shift register for the serial receive path. Collects one data bit
// per qualified SCL rising edge, assembles DATA_WIDTH-bit frames and pushes
// each completed frame into a first-word-fall-through FIFO.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   sda_in              serial data bit
//   rising_edge_found   single-cycle strobe qualifying a bit sample
//   rx_enable           samples ignored while low (frame state holds)
//   abort               discards the partial frame (start/stop condition)
//   rd_en               pops the FIFO head
//   clr_ovf             clears the sticky overflow flag
//   rd_data             FIFO head, 0 while empty
//   empty, full, count  FIFO status
//   frame_done          one-cycle pulse per completed frame (even if dropped)
//   overflow            sticky, set when a completed frame is dropped
//   bit_cnt             bits held in the current partial frame
module rx_frame_sr #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int MSB_FIRST  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sda_in,
    input  logic                          rising_edge_found,
    input  logic                          rx_enable,
    input  logic                          abort,
    input  logic                          rd_en,
    input  logic                          clr_ovf,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          frame_done,
    output logic                          overflow,
    output logic [$clog2(DATA_WIDTH)-1:0] bit_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] sr;
    logic [DATA_WIDTH-1:0] sr_shift;
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    logic sample;
    logic word_done;
    logic do_rd;
    logic do_wr;
    logic drop;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign sr_shift = {sr[DATA_WIDTH-2:0], sda_in};
        end else begin : g_lsb_first
            assign sr_shift = {sda_in, sr[DATA_WIDTH-1:1]};
        end
    endgenerate

    assign sample    = rising_edge_found & rx_enable & ~abort;
    assign word_done = sample & (bit_cnt == LAST_BIT);

    // A pop is only real when something is stored; this also makes a
    // simultaneous write+read on an empty FIFO behave as a plain write.
    assign do_rd = rd_en & ~empty;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign do_wr = word_done & (~full | do_rd);
    assign drop  = word_done & full & ~do_rd;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Frame assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (abort) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (sample) begin
            if (word_done) begin
                sr      <= '0;
                bit_cnt <= '0;
            end else begin
                sr      <= sr_shift;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // FIFO storage; contents are never visible while empty, so no reset
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= sr_shift;
        end
    end

    // FIFO pointers, occupancy and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= word_done;
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (!do_wr && do_rd) begin
                count <= count - 1'b1;
            end
            // A drop in the same cycle as a clear leaves the flag set
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_sr.sv
module tb_rx_frame_sr;

    logic clk = 1'b0;
    logic rst, sda_in, rising_edge_found, rx_enable, abort, rd_en, clr_ovf;

    logic [7:0] rd_data,  rd_data_l;
    logic       empty,    empty_l;
    logic       full,     full_l;
    logic [4:0] count,    count_l;
    logic       frame_done, frame_done_l;
    logic       overflow, overflow_l;
    logic [2:0] bit_cnt,  bit_cnt_l;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rx_frame_sr #(.DATA_WIDTH(8), .DEPTH(16), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .sda_in(sda_in),
        .rising_edge_found(rising_edge_found), .rx_enable(rx_enable),
        .abort(abort), .rd_en(rd_en), .clr_ovf(clr_ovf),
        .rd_data(rd_data), .empty(empty), .full(full), .count(count),
        .frame_done(frame_done), .overflow(overflow), .bit_cnt(bit_cnt)
    );

    rx_frame_sr #(.DATA_WIDTH(8), .DEPTH(16), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .sda_in(sda_in),
        .rising_edge_found(rising_edge_found), .rx_enable(rx_enable),
        .abort(abort), .rd_en(rd_en), .clr_ovf(clr_ovf),
        .rd_data(rd_data_l), .empty(empty_l), .full(full_l), .count(count_l),
        .frame_done(frame_done_l), .overflow(overflow_l), .bit_cnt(bit_cnt_l)
    );

    // All stimulus tasks start and end at a falling edge.
    task automatic strobe(input logic b, input logic rd);
        sda_in = b;
        rising_edge_found = 1'b1;
        rd_en = rd;
        @(negedge clk);
        rising_edge_found = 1'b0;
        rd_en = 1'b0;
    endtask

    // Sends v MSB first, strobing every cycle; optional rd_en with last bit.
    task automatic send_frame(input logic [7:0] v, input logic rd_last);
        for (int i = 7; i >= 0; i--) begin
            strobe(v[i], (i == 0) ? rd_last : 1'b0);
        end
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({rd_data, empty, full, count, frame_done, overflow, bit_cnt} !==
            {8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL reset_msb got rd=%h e=%b f=%b c=%0d fd=%b ov=%b bc=%0d",
                     rd_data, empty, full, count, frame_done, overflow, bit_cnt);
        end
        checks++;
        if ({rd_data_l, empty_l, full_l, count_l, frame_done_l, overflow_l, bit_cnt_l} !==
            {8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL reset_lsb got rd=%h e=%b f=%b c=%0d fd=%b ov=%b bc=%0d",
                     rd_data_l, empty_l, full_l, count_l, frame_done_l, overflow_l, bit_cnt_l);
        end
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b0);
        checks++;
        if ({frame_done, rd_data, count, empty} !== {1'b1, 8'hA5, 5'd1, 1'b0}) begin
            failures++;
            $display("FAIL basic_msb got fd=%b rd=%h c=%0d e=%b want 1 a5 1 0",
                     frame_done, rd_data, count, empty);
        end
        checks++;
        if (rd_data_l !== 8'hA5) begin
            failures++;
            $display("FAIL basic_lsb_a5 got %h want a5", rd_data_l);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL frame_done_width got %b want 0", frame_done);
        end
        pop_one();
        checks++;
        if ({empty, rd_data, count} !== {1'b1, 8'h00, 5'd0}) begin
            failures++;
            $display("FAIL basic_pop got e=%b rd=%h c=%0d want 1 00 0", empty, rd_data, count);
        end
        send_frame(8'hF0, 1'b0);
        checks++;
        if ({rd_data, rd_data_l} !== {8'hF0, 8'h0F}) begin
            failures++;
            $display("FAIL bit_order got msb=%h lsb=%h want f0 0f", rd_data, rd_data_l);
        end
        pop_one();
    endtask

    task automatic test_abort();
        for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0);
        checks++;
        if (bit_cnt !== 3'd5) begin
            failures++;
            $display("FAIL partial_bit_cnt got %0d want 5", bit_cnt);
        end
        abort = 1'b1;
        rising_edge_found = 1'b1;  // abort must override a coincident strobe
        @(negedge clk);
        abort = 1'b0;
        rising_edge_found = 1'b0;
        checks++;
        if ({bit_cnt, count} !== {3'd0, 5'd0}) begin
            failures++;
            $display("FAIL abort_clear got bc=%0d c=%0d want 0 0", bit_cnt, count);
        end
        send_frame(8'h3C, 1'b0);
        checks++;
        if ({frame_done, rd_data, count} !== {1'b1, 8'h3C, 5'd1}) begin
            failures++;
            $display("FAIL abort_frame got fd=%b rd=%h c=%0d want 1 3c 1",
                     frame_done, rd_data, count);
        end
        pop_one();
    endtask

    task automatic test_enable();
        logic [7:0] v;
        v = 8'h96;
        for (int i = 7; i >= 0; i--) begin
            rx_enable = 1'b0;
            strobe(~v[i], 1'b0);
            @(negedge clk);
            rx_enable = 1'b1;
            strobe(v[i], 1'b0);
            if (i == 4) begin
                checks++;
                if (bit_cnt !== 3'd4) begin
                    failures++;
                    $display("FAIL enable_bit_cnt got %0d want 4", bit_cnt);
                end
            end
        end
        checks++;
        if ({frame_done, rd_data, count} !== {1'b1, 8'h96, 5'd1}) begin
            failures++;
            $display("FAIL enable_frame got fd=%b rd=%h c=%0d want 1 96 1",
                     frame_done, rd_data, count);
        end
        pop_one();
    endtask

    task automatic test_empty_write_read();
        send_frame(8'h5A, 1'b1);
        checks++;
        if ({count, rd_data, empty} !== {5'd1, 8'h5A, 1'b0}) begin
            failures++;
            $display("FAIL empty_wr_rd got c=%0d rd=%h e=%b want 1 5a 0", count, rd_data, empty);
        end
        pop_one();
    endtask

    task automatic test_overflow();
        for (int f = 0; f < 16; f++) send_frame(8'(f), 1'b0);
        checks++;
        if ({full, count, overflow, rd_data} !== {1'b1, 5'd16, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL fill got full=%b c=%0d ov=%b rd=%h want 1 16 0 00",
                     full, count, overflow, rd_data);
        end
        send_frame(8'h10, 1'b1);
        checks++;
        if ({count, overflow, rd_data, frame_done} !== {5'd16, 1'b0, 8'h01, 1'b1}) begin
            failures++;
            $display("FAIL full_wr_rd got c=%0d ov=%b rd=%h fd=%b want 16 0 01 1",
                     count, overflow, rd_data, frame_done);
        end
        send_frame(8'hAA, 1'b0);
        checks++;
        if ({count, overflow, frame_done} !== {5'd16, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL drop got c=%0d ov=%b fd=%b want 16 1 1", count, overflow, frame_done);
        end
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (rd_data !== 8'(i) || count !== 5'(17 - i)) begin
                failures++;
                $display("FAIL pop_order idx=%0d got rd=%h c=%0d want %h %0d",
                         i, rd_data, count, 8'(i), 17 - i);
            end
            pop_one();
        end
        checks++;
        if ({empty, rd_data, count, overflow} !== {1'b1, 8'h00, 5'd0, 1'b1}) begin
            failures++;
            $display("FAIL drained got e=%b rd=%h c=%0d ov=%b want 1 00 0 1",
                     empty, rd_data, count, overflow);
        end
        rd_en = 1'b1;
        clr_ovf = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        clr_ovf = 1'b0;
        checks++;
        if ({overflow, count, empty} !== {1'b0, 5'd0, 1'b1}) begin
            failures++;
            $display("FAIL clr_ovf got ov=%b c=%0d e=%b want 0 0 1", overflow, count, empty);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits;
        bits = 16'hC35A;
        rising_edge_found = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            sda_in = bits[i];
            @(negedge clk);
            if (i == 8) begin
                checks++;
                if ({frame_done, count, rd_data} !== {1'b1, 5'd1, 8'hC3}) begin
                    failures++;
                    $display("FAIL b2b_first got fd=%b c=%0d rd=%h want 1 1 c3",
                             frame_done, count, rd_data);
                end
            end
        end
        rising_edge_found = 1'b0;
        checks++;
        if ({frame_done, count, rd_data} !== {1'b1, 5'd2, 8'hC3}) begin
            failures++;
            $display("FAIL b2b_second got fd=%b c=%0d rd=%h want 1 2 c3",
                     frame_done, count, rd_data);
        end
        pop_one();
        checks++;
        if ({count, rd_data} !== {5'd1, 8'h5A}) begin
            failures++;
            $display("FAIL b2b_pop got c=%0d rd=%h want 1 5a", count, rd_data);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({rd_data, empty, full, count, frame_done, overflow, bit_cnt} !==
            {8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL mid_reset got rd=%h e=%b f=%b c=%0d fd=%b ov=%b bc=%0d",
                     rd_data, empty, full, count, frame_done, overflow, bit_cnt);
        end
        send_frame(8'h81, 1'b0);
        checks++;
        if ({rd_data, count} !== {8'h81, 5'd1}) begin
            failures++;
            $display("FAIL after_reset got rd=%h c=%0d want 81 1", rd_data, count);
        end
    endtask

    initial begin
        rst = 1'b1;
        sda_in = 1'b0;
        rising_edge_found = 1'b0;
        rx_enable = 1'b1;
        abort = 1'b0;
        rd_en = 1'b0;
        clr_ovf = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_abort();
        test_enable();
        test_empty_write_read();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
